vga_window_timing: RTL and testbench
====================================

Name: vga_window_timing

Overview:
- Parametrised successor to the fixed QVGA-in-VGA display core.
- Generates VGA timing from parameters and places an IMG_W x IMG_H frame-buffer image at a programmable window offset, with integer pixel replication (SCALE).
- Compensates a configurable frame-buffer read latency and drives RGB444 VGA pins plus an aligned video stream (tdata/tvalid/tlast/fsync) toward the capture/DMA path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- IMG_W, 320, source image width
- IMG_H, 240, source image height
- SCALE, 1, replication factor; must be 1, 2 or 4
- WIN_X, 160, first active column of the window
- WIN_Y, 120, first active line of the window
- RD_LAT, 1, frame-buffer read latency in cycles; range 1..4
- AW, 17, frame address width

Ports:
- clk25, input, 1, pixel clock
- resetn, input, 1, synchronous active-low reset
- frame_addr, output, AW, frame-buffer read address
- frame_pixel, input, 16, RGB444 pixel in [11:0]; [15:12] ignored
- vga_red, output, 4, red
- vga_green, output, 4, green
- vga_blue, output, 4, blue
- vga_hsync, output, 1, horizontal sync
- vga_vsync, output, 1, vertical sync
- HCnt, output, 11, raw horizontal counter
- VCnt, output, 11, raw vertical counter
- tdata, output, 24, RGB888 {r,r,g,g,b,b} (each nibble replicated)
- tvalid, output, 1, active-area pixel valid
- tlast, output, 1, last active pixel of a line
- fsync, output, 1, first active pixel of a frame

Behaviour:
- Reset (resetn=0 on a clock edge):
  - HCnt, VCnt, frame_addr, colours, tdata, tvalid, tlast and fsync go to 0.
  - Syncs go to ~POL.
  - The delay pipeline is flushed to blank/inactive.
  - Reset mid-frame restarts at (0,0) the next cycle.
- Counters:
  - HCnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - On wrap, VCnt increments, wrapping at V_TOTAL-1.
- Stage-0 decode, from the counters:
  - active = HCnt<H_ACTIVE && VCnt<V_ACTIVE.
  - hs = HCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs: same rule on VCnt.
  - in_win = active && HCnt in [WIN_X, WIN_X+IMG_W*SCALE) && VCnt in [WIN_Y, WIN_Y+IMG_H*SCALE).
  - The window is clipped to the active area.
- Address generator (no multiplier):
  - Holds a line-base register, a column index and replication counters.
  - Inside the window, the column index advances every SCALE pixels.
  - At the end of a window line, line_base += IMG_W every SCALE window lines.
  - Outside the window rows, line_base = 0.
  - frame_addr = line_base + column index; it is registered and valid in the same cycle in_win is decoded.
- Alignment:
  - active, hs, vs, in_win and the end-of-line/frame flags are delayed RD_LAT+1 cycles so that frame_pixel lines up with them.
  - Registered outputs therefore appear RD_LAT+1 cycles after the counter value that produced them.
  - HCnt/VCnt are raw (not delayed).
- Colour:
  - When delayed in_win is set, colour = frame_pixel[11:0].
  - Otherwise colour = 0.
- Stream:
  - tvalid = delayed active; this covers the whole active area, with zeros outside the window.
  - tdata is driven from the same colour.
  - tlast = delayed (HCnt==H_ACTIVE-1 && active).
  - fsync = delayed (HCnt==0 && VCnt==0).
  - There is no back-pressure; the consumer must accept every beat.
- Per frame:
  - Exactly V_ACTIVE tlast pulses and one fsync.
  - Exactly H_ACTIVE tvalid cycles per active line.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined, an extra input port test_mode (1 bit) is present.
- While test_mode=1:
  - The colour source becomes 8 vertical bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black (RGB444 F/0 levels).
  - The bars cover the whole active area.
  - Pipeline alignment is unchanged.
- When not defined: no port, and behaviour is exactly as above.

Decomposition:
- Package vga_pkg holds:
  - the rgb444_t and rgb888_t typedefs;
  - the function expand444to888;
  - the 640x480@60 default timing constants;
  - the test-bar colour constants.
- Sub-module vga_delay_line: a parametrised-width, parametrised-depth shift register with synchronous active-low clear, used for the RD_LAT+1 alignment.

Test Plan:
- Defaults, counters only:
  - vga_hsync is low for exactly 96 cycles, starting RD_LAT+1 cycles after HCnt=656.
  - vga_vsync is low for lines 490-491.
  - One frame is 420000 cycles.
- Defaults, addressing:
  - frame_addr=0 at (160,120).
  - frame_addr=319 at (479,120).
  - frame_addr=320 at (160,121).
  - Last address 76799 at (479,359).
  - Colour equals frame_pixel only inside the window.
- SCALE=2, WIN_X=0, WIN_Y=0:
  - Each address is held 2 cycles and each line base repeats for 2 lines.
  - The address reaches 76799 at (639,479).
- Stream counts:
  - 640 tvalid cycles per line and 480 tlast pulses per frame.
  - fsync coincides with the first tvalid of the frame.
  - With RD_LAT=3, the latency to pins is 4 cycles.
- Reset:
  - Assert resetn=0 at HCnt=300, VCnt=200 for 2 cycles.
  - All outputs read 0 (syncs read inactive) on the next edge.
  - After release, the counters restart from 0 and the next fsync arrives after one full frame.
- With VGA_TEST_PATTERN_EN and test_mode=1:
  - Pixels at HCnt 0/80/560 show 0xFFF/0xFF0/0x000.
  - tdata for the first of these is 0xFFFFFF.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared colour types, 640x480@60 default timing and test-bar colours.
package vga_pkg;
  typedef logic [11:0] rgb444_t;
  typedef logic [23:0] rgb888_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam rgb444_t BAR_WHITE   = 12'hFFF;
  localparam rgb444_t BAR_YELLOW  = 12'hFF0;
  localparam rgb444_t BAR_CYAN    = 12'h0FF;
  localparam rgb444_t BAR_GREEN   = 12'h0F0;
  localparam rgb444_t BAR_MAGENTA = 12'hF0F;
  localparam rgb444_t BAR_RED     = 12'hF00;
  localparam rgb444_t BAR_BLUE    = 12'h00F;
  localparam rgb444_t BAR_BLACK   = 12'h000;

  function automatic rgb888_t expand444to888(input rgb444_t c);
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  function automatic rgb444_t test_bar(input logic [2:0] i);
    return i[2] ? (i[1] ? (i[0] ? BAR_BLACK : BAR_BLUE) : (i[0] ? BAR_RED : BAR_MAGENTA))
                : (i[1] ? (i[0] ? BAR_GREEN : BAR_CYAN) : (i[0] ? BAR_YELLOW : BAR_WHITE));
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit, D-deep shift register with synchronous active-low clear.
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < D; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[D-1];
endmodule

// File: rtl/vga_window_timing.sv
// vga_window_timing: parametrised VGA timing, scaled frame-buffer window and aligned RGB888 stream.
// Define VGA_TEST_PATTERN_EN to add the test_mode input selecting eight full-screen colour bars.
module vga_window_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int SCALE    = 1,
  parameter int WIN_X    = 160,
  parameter int WIN_Y    = 120,
  parameter int RD_LAT   = 1,
  parameter int AW       = 17
) (
  input  logic          clk25,
  input  logic          resetn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic          test_mode,
`endif
  output logic [AW-1:0] frame_addr,
  input  logic [15:0]   frame_pixel,
  output logic [3:0]    vga_red,
  output logic [3:0]    vga_green,
  output logic [3:0]    vga_blue,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [10:0]   HCnt,
  output logic [10:0]   VCnt,
  output logic [23:0]   tdata,
  output logic          tvalid,
  output logic          tlast,
  output logic          fsync
);
  localparam int XEND = (WIN_X + IMG_W*SCALE < H_ACTIVE) ? WIN_X + IMG_W*SCALE : H_ACTIVE;
  localparam int YEND = (WIN_Y + IMG_H*SCALE < V_ACTIVE) ? WIN_Y + IMG_H*SCALE : V_ACTIVE;
  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HT1 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HSB = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSE = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VT1 = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VSB = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSE = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] WX  = 11'(WIN_X);
  localparam logic [10:0] XE  = 11'(XEND);
  localparam logic [10:0] WY  = 11'(WIN_Y);
  localparam logic [10:0] YE  = 11'(YEND);
  localparam logic [1:0]  SM1 = 2'(SCALE - 1);
  localparam logic [AW-1:0] IW = AW'(IMG_W);
  localparam logic HP = 1'(HS_POL);
  localparam logic VP = 1'(VS_POL);
`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = 9;
  localparam int BW = H_ACTIVE / 8;
`else
  localparam int DW = 6;
`endif

  logic [10:0] h, v;
  logic active, hs, vs, win_row, in_win, eol, sof;
  logic [AW-1:0] col, col_n, line_base, lb_n;
  logic [1:0] hrep, hrep_n, vrep, vrep_n;
  logic [DW-1:0] d, q;
  rgb444_t colour, pix_n;
  logic unused_pix;

  assign HCnt = h;
  assign VCnt = v;
  assign unused_pix = &frame_pixel[15:12];

  assign active  = h < HA && v < VA;
  assign hs      = h >= HSB && h < HSE;
  assign vs      = v >= VSB && v < VSE;
  assign win_row = v >= WY && v < YE;
  assign in_win  = active && win_row && h >= WX && h < XE;
  assign eol     = active && h == HA - 11'd1;
  assign sof     = h == 11'd0 && v == 11'd0;

  // Address state tracks the pixel under the counters; the next-state sum is
  // registered so frame_addr matches the counter value it belongs to.
  always_comb begin
    col_n  = col;
    hrep_n = hrep;
    lb_n   = line_base;
    vrep_n = vrep;
    if (!win_row) begin
      col_n  = '0;
      hrep_n = '0;
      lb_n   = '0;
      vrep_n = '0;
    end else if (in_win) begin
      if (h == XE - 11'd1) begin
        col_n  = '0;
        hrep_n = '0;
        vrep_n = (vrep == SM1) ? 2'd0 : vrep + 2'd1;
        lb_n   = (vrep == SM1) ? line_base + IW : line_base;
      end else begin
        hrep_n = (hrep == SM1) ? 2'd0 : hrep + 2'd1;
        col_n  = (hrep == SM1) ? col + AW'(1) : col;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (!resetn) begin
      h          <= '0;
      v          <= '0;
      col        <= '0;
      hrep       <= '0;
      line_base  <= '0;
      vrep       <= '0;
      frame_addr <= '0;
    end else begin
      h          <= (h == HT1) ? 11'd0 : h + 11'd1;
      v          <= (h == HT1) ? ((v == VT1) ? 11'd0 : v + 11'd1) : v;
      col        <= col_n;
      hrep       <= hrep_n;
      line_base  <= lb_n;
      vrep       <= vrep_n;
      frame_addr <= lb_n + col_n;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) if (h >= 11'(k*BW)) bar = 3'(k);
  end
  assign d     = {bar, sof, eol, in_win, vs, hs, active};
  assign pix_n = test_mode ? (q[0] ? test_bar(q[8:6]) : '0) : (q[3] ? frame_pixel[11:0] : '0);
`else
  assign d     = {sof, eol, in_win, vs, hs, active};
  assign pix_n = q[3] ? frame_pixel[11:0] : '0;
`endif

  // RD_LAT stages here plus the output register give RD_LAT+1 total alignment.
  vga_delay_line #(.W(DW), .D(RD_LAT)) u_dly (
    .clk    (clk25),
    .resetn (resetn),
    .d      (d),
    .q      (q)
  );

  always_ff @(posedge clk25) begin
    if (!resetn) begin
      colour    <= '0;
      vga_hsync <= ~HP;
      vga_vsync <= ~VP;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      fsync     <= 1'b0;
    end else begin
      colour    <= pix_n;
      vga_hsync <= q[1] ? HP : ~HP;
      vga_vsync <= q[2] ? VP : ~VP;
      tvalid    <= q[0];
      tlast     <= q[4];
      fsync     <= q[5];
    end
  end

  assign vga_red   = colour[11:8];
  assign vga_green = colour[7:4];
  assign vga_blue  = colour[3:0];
  assign tdata     = expand444to888(colour);
endmodule

// File: tb/tb_vga_window_timing.sv
// tb_vga_window_timing: directed checks of a reduced-size timing with a scaled window and RD_LAT=2.
module tb_vga_window_timing;
  localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6, HT = HA + HFP + HSY + HBP;
  localparam int VA = 12, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int IW = 6, IH = 4, SC = 2, WX = 8, WY = 2, RL = 2, L = RL + 1;
  localparam int HSP = 0, VSP = 1;
  localparam int XE = WX + IW*SC, YE = WY + IH*SC, FRAME = HT*VT;
  localparam int HSB = HA + HFP, HSE = HSB + HSY, VSB = VA + VFP, VSE = VSB + VSY;

  logic clk = 1'b0, resetn = 1'b0;
  logic [16:0] frame_addr;
  logic [15:0] frame_pixel;
  logic [3:0]  r, g, b;
  logic        hsy, vsy, tvalid, tlast, fsync;
  logic [10:0] hc, vc;
  logic [23:0] tdata;
  logic [15:0] pipe [RL];
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
  int n_assert = 0, n_fail = 0, tv_cnt, tl_cnt, fs_cnt;
  bit tm = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_window_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .IMG_W(IW), .IMG_H(IH), .SCALE(SC),
    .WIN_X(WX), .WIN_Y(WY), .RD_LAT(RL), .AW(17)
  ) dut (
    .clk25(clk), .resetn(resetn),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .frame_addr(frame_addr), .frame_pixel(frame_pixel),
    .vga_red(r), .vga_green(g), .vga_blue(b), .vga_hsync(hsy), .vga_vsync(vsy),
    .HCnt(hc), .VCnt(vc), .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .fsync(fsync)
  );

  function automatic logic [15:0] pix(input int a);
    logic [11:0] t;
    t = 12'(a*37 + 5);
    return {4'hA, t};
  endfunction

  function automatic bit win_at(input int h, input int v);
    return h >= WX && h < XE && v >= WY && v < YE;
  endfunction

  function automatic int addr_of(input int h, input int v);
    return ((v - WY) / SC) * IW + (h - WX) / SC;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= pix(int'(frame_addr));
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign frame_pixel = pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_hcnt", 32'(hc), 0);
    chk("rst_vcnt", 32'(vc), 0);
    chk("rst_addr", 32'(frame_addr), 0);
    chk("rst_rgb", 32'({r, g, b}), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_flags", 32'({tvalid, tlast, fsync}), 0);
    chk("rst_hsync", 32'(hsy), 1 - HSP);
    chk("rst_vsync", 32'(vsy), 1 - VSP);
  endtask

  task automatic check_cycle(input int n);
    int h, v, ph, pv;
    bit act;
    logic [15:0] px;
    logic [11:0] c;
    logic [7:0] r8, g8, b8;
    h = n % HT;
    v = (n / HT) % VT;
    chk("hcnt", 32'(hc), h);
    chk("vcnt", 32'(vc), v);
    if (win_at(h, v)) chk("addr", 32'(frame_addr), addr_of(h, v));
    if (v == 2 && h == 8)  chk("addr_first", 32'(frame_addr), 0);
    if (v == 2 && h == 9)  chk("addr_hold", 32'(frame_addr), 0);
    if (v == 2 && h == 10) chk("addr_step", 32'(frame_addr), 1);
    if (v == 2 && h == 19) chk("addr_eol", 32'(frame_addr), 5);
    if (v == 3 && h == 8)  chk("addr_rowrep", 32'(frame_addr), 0);
    if (v == 4 && h == 8)  chk("addr_row2", 32'(frame_addr), 6);
    if (v == 9 && h == 19) chk("addr_last", 32'(frame_addr), 23);
    if (n < L) begin
      chk("pre_rgb", 32'({r, g, b}), 0);
      chk("pre_flags", 32'({tvalid, tlast, fsync}), 0);
      chk("pre_hsync", 32'(hsy), 1 - HSP);
      chk("pre_vsync", 32'(vsy), 1 - VSP);
    end else begin
      ph = (n - L) % HT;
      pv = ((n - L) / HT) % VT;
      act = ph < HA && pv < VA;
      px = pix(addr_of(ph, pv));
      c = tm ? (act ? bars[ph / 4] : 12'h000) : (win_at(ph, pv) ? px[11:0] : 12'h000);
      r8 = {4'h0, c[11:8]} * 8'd17;
      g8 = {4'h0, c[7:4]} * 8'd17;
      b8 = {4'h0, c[3:0]} * 8'd17;
      chk("rgb", 32'({r, g, b}), 32'(c));
      chk("tdata", 32'(tdata), 32'({r8, g8, b8}));
      chk("tvalid", 32'(tvalid), 32'(act));
      chk("tlast", 32'(tlast), 32'(act && ph == HA - 1));
      chk("fsync", 32'(fsync), 32'(ph == 0 && pv == 0));
      chk("hsync", 32'(hsy), (ph >= HSB && ph < HSE) ? HSP : 1 - HSP);
      chk("vsync", 32'(vsy), (pv >= VSB && pv < VSE) ? VSP : 1 - VSP);
      if (tm && pv == 1 && ph == 0) chk("bar_white_tdata", 32'(tdata), 32'h00FFFFFF);
      if (tm && pv == 1 && ph == 0) chk("bar_white", 32'({r, g, b}), 32'hFFF);
      if (tm && pv == 1 && ph == 4) chk("bar_yellow", 32'({r, g, b}), 32'hFF0);
      if (tm && pv == 1 && ph == 28) chk("bar_black", 32'({r, g, b}), 32'h000);
      if (n < L + FRAME) begin
        tv_cnt += int'(tvalid);
        tl_cnt += int'(tlast);
        fs_cnt += int'(fsync);
      end
    end
  endtask

  task automatic run(input int ncyc);
    tv_cnt = 0;
    tl_cnt = 0;
    fs_cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      check_cycle(n);
      @(negedge clk);
    end
    chk("tvalid_count", tv_cnt, HA*VA);
    chk("tlast_count", tl_cnt, VA);
    chk("fsync_count", fs_cnt, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    resetn = 1'b1;
    run(FRAME + 5*HT + 12);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset();
    @(negedge clk);
    resetn = 1'b1;
    run(FRAME + L + 1);
`ifdef VGA_TEST_PATTERN_EN
    resetn = 1'b0;
    test_mode = 1'b1;
    tm = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset();
    resetn = 1'b1;
    run(FRAME + L + 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
